// File: rtl/clock_tick_generator_pkg.sv
// Shared definitions for the CPU clock tick generator and its panel-button helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_tick_defs;

  // Tick generator modes; encoding is fixed so debug logic can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } tick_state_t;

  // Flops between an asynchronous panel input and its first use.
  localparam int SYNC_DEPTH = 2;

  // A burst length of zero still produces one tick.
  function automatic logic [7:0] burst_load(input logic [7:0] burst_count);
    return (burst_count == 8'd0) ? 8'd1 : burst_count;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces a bouncy push button and flags its rising edge.
// Latency: level changes SYNC_DEPTH + 2^DebounceBits edges after the input settles; rise lasts one cycle.
// Backpressure: none; rise is a single-cycle pulse that is lost if the consumer ignores it.
//
// Ports:
//   GlobalClock  system clock
//   Reset        asynchronous, active-high
//   button       raw asynchronous button level
//   level        debounced button level
//   rise         one-cycle pulse on a debounced 0->1 transition
module button_debouncer
  import clock_tick_defs::*;
#(
  parameter int DebounceBits = 4
) (
  input  logic GlobalClock,
  input  logic Reset,
  input  logic button,
  output logic level,
  output logic rise
);

  logic [SYNC_DEPTH-1:0]   sync_q;
  logic                    synced;
  logic [DebounceBits-1:0] stable_cnt;
  logic                    level_d;

  assign synced = sync_q[SYNC_DEPTH-1];

  // The counter tracks how many consecutive samples have disagreed with the
  // current debounced level; the level only follows once the counter is
  // saturated and the disagreement is still present, i.e. after 2^DebounceBits
  // consecutive stable samples. Any agreeing sample restarts the window.
  always_ff @(posedge GlobalClock or posedge Reset) begin
    if (Reset) begin
      sync_q     <= '0;
      stable_cnt <= '0;
      level      <= 1'b0;
      level_d    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_DEPTH-2:0], button};
      level_d <= level;
      if (synced != level) begin
        if (stable_cnt == '1) begin
          level      <= synced;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + DebounceBits'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/clock_tick_generator.sv
// Generates the ClockTick enable that advances the derived CPU clock: free-run, step burst, or halted.
// Latency: first tick DivideValue+3 edges after Run is sampled, DivideValue+3+2^DebounceBits after a step press.
// Backpressure: none; ClockTick is an enable with no ready, and step presses arriving outside IDLE are dropped.
//
// Ports:
//   GlobalClock  system clock (only clock used)
//   Reset        asynchronous, active-high
//   Run          asynchronous switch level, 1 = free-run
//   StepButton   asynchronous bouncy button, rising edge requests a burst
//   BurstCount   ticks per step press (0 behaves as 1), sampled on burst entry
//   DivideValue  tick period minus one, sampled at every divider reload
//   ClockTick    registered one-cycle tick enable
//   Running      high while the FSM is in RUN or BURST
//   TickCount    total ticks issued, wraps
module clock_tick_generator
  import clock_tick_defs::*;
#(
  parameter int NrOfBits      = 16,
  parameter int DebounceBits  = 4,
  parameter int TickCountBits = 32
) (
  input  logic                     GlobalClock,
  input  logic                     Reset,
  input  logic                     Run,
  input  logic                     StepButton,
  input  logic [7:0]               BurstCount,
  input  logic [NrOfBits-1:0]      DivideValue,
  output logic                     ClockTick,
  output logic                     Running,
  output logic [TickCountBits-1:0] TickCount
);

  tick_state_t           state_q, state_d;
  logic [NrOfBits-1:0]   divider_q, divider_d;
  logic [7:0]            remaining_q, remaining_d;
  logic                  tick_d;
  logic [SYNC_DEPTH-1:0] run_sync_q;
  logic                  run_sync;
  logic                  step_level;
  logic                  step_req;

  // Run is a switch, so it only needs synchronizing, not debouncing.
  always_ff @(posedge GlobalClock or posedge Reset) begin
    if (Reset) begin
      run_sync_q <= '0;
    end else begin
      run_sync_q <= {run_sync_q[SYNC_DEPTH-2:0], Run};
    end
  end

  assign run_sync = run_sync_q[SYNC_DEPTH-1];

  button_debouncer #(
    .DebounceBits (DebounceBits)
  ) u_step_debouncer (
    .GlobalClock (GlobalClock),
    .Reset       (Reset),
    .button      (StepButton),
    .level       (step_level),
    .rise        (step_req)
  );

  always_comb begin
    state_d     = state_q;
    divider_d   = divider_q;
    remaining_d = remaining_q;
    tick_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // Run wins over a simultaneous step request.
        if (run_sync) begin
          state_d   = RUN;
          divider_d = DivideValue;
        end else if (step_req) begin
          state_d     = BURST;
          divider_d   = DivideValue;
          remaining_d = burst_load(BurstCount);
        end
      end
      RUN: begin
        // Leaving RUN drops a tick that would have fired on this edge.
        if (!run_sync) begin
          state_d = IDLE;
        end else if (divider_q == '0) begin
          tick_d    = 1'b1;
          divider_d = DivideValue;
        end else begin
          divider_d = divider_q - NrOfBits'(1);
        end
      end
      BURST: begin
        // A burst always runs to completion; Run only decides where it ends up,
        // and the reload on the last tick lets RUN continue without a gap.
        if (divider_q == '0) begin
          tick_d      = 1'b1;
          divider_d   = DivideValue;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = run_sync ? RUN : IDLE;
          end
        end else begin
          divider_d = divider_q - NrOfBits'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge GlobalClock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      divider_q   <= '0;
      remaining_q <= 8'd0;
      ClockTick   <= 1'b0;
      Running     <= 1'b0;
      TickCount   <= '0;
    end else begin
      state_q     <= state_d;
      divider_q   <= divider_d;
      remaining_q <= remaining_d;
      ClockTick   <= tick_d;
      Running     <= (state_d != IDLE);
      TickCount   <= TickCount + TickCountBits'(tick_d);
    end
  end

endmodule

// File: tb/tb_clock_tick_generator.sv
module tb_clock_tick_generator;

  logic        GlobalClock;
  logic        Reset;
  logic        Run;
  logic        StepButton;
  logic [7:0]  BurstCount;
  logic [15:0] DivideValue;
  logic        ClockTick;
  logic        Running;
  logic [31:0] TickCount;
  logic        ClockTick_w;
  logic        Running_w;
  logic [3:0]  TickCount_w;

  // Main instance: short debounce window so step tests stay compact.
  clock_tick_generator #(.NrOfBits(16), .DebounceBits(2), .TickCountBits(32)) dut (
    .GlobalClock (GlobalClock),
    .Reset       (Reset),
    .Run         (Run),
    .StepButton  (StepButton),
    .BurstCount  (BurstCount),
    .DivideValue (DivideValue),
    .ClockTick   (ClockTick),
    .Running     (Running),
    .TickCount   (TickCount)
  );

  // Narrow tick counter instance, same stimulus, used to see the 15->0 wrap.
  clock_tick_generator #(.NrOfBits(16), .DebounceBits(2), .TickCountBits(4)) dut_w (
    .GlobalClock (GlobalClock),
    .Reset       (Reset),
    .Run         (Run),
    .StepButton  (StepButton),
    .BurstCount  (BurstCount),
    .DivideValue (DivideValue),
    .ClockTick   (ClockTick_w),
    .Running     (Running_w),
    .TickCount   (TickCount_w)
  );

  initial GlobalClock = 1'b0;
  always #5 GlobalClock = ~GlobalClock;

  int cyc = 0;
  always @(posedge GlobalClock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_tick(input int c);
    exp_t e;
    exp_count++;
    e.cyc = c;
    e.cnt = exp_count;
    exp_q.push_back(e);
  endtask

  task automatic tick_edges(input int n);
    repeat (n) @(posedge GlobalClock);
    #1;
  endtask

  task automatic until_cyc(input int t);
    while (cyc < t) begin
      @(posedge GlobalClock);
      #1;
    end
  endtask

  task automatic do_reset();
    chk("queue_drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    Reset = 1'b1;
    #1;
    chk("reset_clocktick", ClockTick, 0);
    chk("reset_running", Running, 0);
    chk("reset_tickcount", TickCount, 0);
    tick_edges(2);
    Reset = 1'b0;
    exp_count = 0;
  endtask

  // Monitor: every tick seen on the falling edge must match the head of the
  // expected queue in both edge number and running count.
  always @(negedge GlobalClock) begin
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_tick actual=no_tick required=tick_at_edge_%0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (ClockTick) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick actual=tick_at_edge_%0d required=no_tick", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tick_edge", cyc, mon_e.cyc);
        chk("tick_count", TickCount, mon_e.cnt);
        chk("tick_w", ClockTick_w, 1);
        chk("tick_count_w4", TickCount_w, mon_e.cnt % 16);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    Reset       = 1'b1;
    Run         = 1'b0;
    StepButton  = 1'b0;
    BurstCount  = 8'd0;
    DivideValue = 16'd0;
    tick_edges(2);
    do_reset();

    // 1: reset in the middle of a run, then re-run.
    DivideValue = 16'd3;
    Run = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 3; i++) push_tick(k + 6 + 4 * i);
    until_cyc(k + 18);
    chk("t1_tick_high_before_reset", ClockTick, 1);
    do_reset();
    k = cyc + 1;
    push_tick(k + 6);
    until_cyc(k + 6);
    Run = 1'b0;
    tick_edges(6);
    chk("t1_running_off", Running, 0);
    chk("t1_tickcount", TickCount, 1);

    // 2: free-run with period 4.
    do_reset();
    DivideValue = 16'd3;
    Run = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 24; i++) push_tick(k + 6 + 4 * i);
    until_cyc(k + 1);
    chk("t2_running_k1", Running, 0);
    until_cyc(k + 2);
    chk("t2_running_k2", Running, 1);
    chk("t2_running_w_k2", Running_w, 1);
    until_cyc(k + 98);
    Run = 1'b0;
    until_cyc(k + 104);
    chk("t2_running_off", Running, 0);
    chk("t2_tickcount", TickCount, 24);

    // 3: DivideValue=0 gives a tick every cycle; narrow counter wraps.
    do_reset();
    DivideValue = 16'd0;
    Run = 1'b1;
    k = cyc + 1;
    for (int i = 3; i <= 24; i++) push_tick(k + i);
    until_cyc(k + 22);
    Run = 1'b0;
    until_cyc(k + 30);
    chk("t3_running_off", Running, 0);
    chk("t3_tickcount", TickCount, 22);
    chk("t3_tickcount_w4", TickCount_w, 6);

    // 4: clean step press, burst of 5 with period 2.
    do_reset();
    DivideValue = 16'd1;
    BurstCount = 8'd5;
    StepButton = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 5; i++) push_tick(k + 8 + 2 * i);
    until_cyc(k + 5);
    chk("t4_running_before", Running, 0);
    until_cyc(k + 6);
    chk("t4_running_enter", Running, 1);
    until_cyc(k + 15);
    chk("t4_running_mid", Running, 1);
    until_cyc(k + 16);
    chk("t4_running_last_tick", Running, 0);
    StepButton = 1'b0;
    tick_edges(10);
    chk("t4_tickcount", TickCount, 5);

    // 5: bouncing press with BurstCount=0 gives exactly one tick.
    do_reset();
    DivideValue = 16'd1;
    BurstCount = 8'd0;
    for (int i = 0; i < 5; i++) begin
      StepButton = (i % 2 == 0);
      if (i == 4) k = cyc + 1;
      tick_edges(2);
    end
    push_tick(k + 8);
    until_cyc(k + 12);
    chk("t5_running_off", Running, 0);
    StepButton = 1'b0;
    tick_edges(8);
    chk("t5_tickcount", TickCount, 1);

    // 5b: a second press during a burst is ignored.
    DivideValue = 16'd7;
    BurstCount = 8'd4;
    StepButton = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 4; i++) push_tick(k + 14 + 8 * i);
    until_cyc(k + 9);
    StepButton = 1'b0;
    until_cyc(k + 19);
    StepButton = 1'b1;
    until_cyc(k + 26);
    chk("t5b_running_during_repress", Running, 1);
    until_cyc(k + 40);
    StepButton = 1'b0;
    until_cyc(k + 60);
    chk("t5b_running_off", Running, 0);
    chk("t5b_tickcount", TickCount, 5);

    // 6: Run raised during a burst continues into RUN without a gap.
    do_reset();
    DivideValue = 16'd2;
    BurstCount = 8'd3;
    StepButton = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 7; i++) push_tick(k + 9 + 3 * i);
    until_cyc(k + 9);
    Run = 1'b1;
    until_cyc(k + 12);
    StepButton = 1'b0;
    until_cyc(k + 16);
    chk("t6_running_after_burst", Running, 1);
    until_cyc(k + 27);
    Run = 1'b0;
    until_cyc(k + 36);
    chk("t6_running_off", Running, 0);
    chk("t6_tickcount", TickCount, 7);
    chk("t6_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_tick_generator.md
Name: clock_tick_generator

Overview:
- Produces the ClockTick enable that the Logisim clock component uses to advance the derived CPU clock.
- Supports three modes: free-running at a programmable divide rate, single-step/burst from a debounced push button, and halted.
- Counts every issued tick so the debug/VGA logic can display CPU cycle count.
- Runs entirely on GlobalClock; no derived clocks are generated here.

Parameters:
- NrOfBits, 16, width of the divider counter and DivideValue.
- DebounceBits, 4, debounce window = 2^DebounceBits consecutive stable samples.
- TickCountBits, 32, width of TickCount.

Ports:
- GlobalClock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  asynchronous level from a switch; 1 = free-run.
- StepButton  in  1  asynchronous, bouncy push button; a rising edge requests a burst.
- BurstCount  in  8  ticks per step press; 0 is treated as 1; sampled on burst entry only.
- DivideValue  in  NrOfBits  tick period = DivideValue+1 cycles; sampled at every counter reload.
- ClockTick  out  1  registered one-cycle tick enable; continuously high when DivideValue=0 in steady state.
- Running  out  1  high when the FSM is not IDLE.
- TickCount  out  TickCountBits  number of ticks issued; wraps modulo 2^TickCountBits.

Behaviour:
- Reset (async) state:
  - FSM=IDLE, ClockTick=0, Running=0, TickCount=0.
  - Divider=0, burst remaining=0.
  - Sync and debounce flops=0, debounced level=0.
- Reset mid-operation aborts everything immediately; no tick is issued in the reset cycle.
- Run path: 2-FF synchronizer (run_sync), no debounce.
- Step path: 2-FF synchronizer, then debouncer.
  - The debounce counter increments while the synced value differs from the debounced level and clears when they match.
  - The debounced level flips at the edge where the counter reaches 2^DebounceBits-1 with a mismatch still present.
  - step_req = debounced & ~debounced_delayed (combinational, one cycle).
- FSM states: IDLE, RUN, BURST.
  - IDLE -> RUN when run_sync=1; Run has priority over step_req in the same cycle.
  - IDLE -> BURST on step_req; remaining <= (BurstCount==0) ? 1 : BurstCount.
  - RUN -> IDLE when run_sync=0. This takes effect at that edge, and any pending tick is dropped.
  - BURST -> on the edge issuing a tick with remaining==1: go to RUN if run_sync=1, else IDLE.
  - BURST: step_req is ignored. Run deassertion has no effect; the burst always completes.
  - RUN: step_req is ignored.
- Divider:
  - Loaded with DivideValue on entry to RUN or BURST from IDLE.
  - In RUN/BURST:
    - When divider==0: ClockTick <= 1 and divider <= DivideValue.
    - Otherwise: ClockTick <= 0 and divider decrements.
  - BURST->RUN keeps reloading with no gap.
  - In IDLE, ClockTick <= 0.
- remaining decrements on each tick issued in BURST.
- TickCount increments on every edge that sets ClockTick=1.
- Running is registered from the next state, so it is high in the same cycles the FSM is in RUN/BURST.
- Latency, with edge k being the first edge sampling the input high:
  - Run: first ClockTick is high after edge k+3+DivideValue.
  - Step: first ClockTick is high after edge k+3+2^DebounceBits+DivideValue.
- DivideValue changes mid-period take effect at the next reload only.

Decomposition:
- Shared package or localparam header clock_tick_defs holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, BURST=2'd2);
  - synchronizer depth constant (2).
- One sub-module, button_debouncer (synchronizer plus debounce counter plus rising-edge pulse, parameterised by DebounceBits). It is reusable for other panel buttons.

Test Plan:
1. Reset mid-run: DivideValue=3, Run=1 for 20 cycles, then pulse Reset.
   -> ClockTick, Running and TickCount go to 0 asynchronously; no tick until Run is re-sampled and 6 cycles elapse.
2. DivideValue=3, Run held high 100 cycles.
   -> First tick after edge k+6, then every 4 cycles; TickCount=24 after the tick at k+98; Running=1 from edge k+2.
3. DivideValue=0, Run=1.
   -> ClockTick continuously high from edge k+3; TickCount increments every cycle; wrap checked with TickCountBits=4 (15->0).
4. DebounceBits=2, DivideValue=1, BurstCount=5, clean step press.
   -> Exactly 5 ticks spaced 2 cycles, first after edge k+8; Running falls on the edge of the 5th tick; TickCount=5.
5. Bounce and zero count: StepButton toggles every 2 cycles for 10 cycles then stays high, with BurstCount=0.
   -> Exactly one burst containing exactly 1 tick; a second press while BURST is ignored.
6. Run asserted during a BurstCount=3 burst, DivideValue=2.
   -> 3 burst ticks, then RUN continues with ticks every 3 cycles with no gap. Deasserting Run then drops to IDLE with no further ticks.
